tdm_agc_ctrl: RTL and testbench
===============================

Name: tdm_agc_ctrl

Overview:
Per-channel automatic gain (fractional-shift) controller for the time-multiplexed FIR output of the multi-channel DDC. It tracks lane order (real0, imag0, real1, imag1, …), keeps one shift value per channel, and applies the shift with saturation to OUT_WIDTH. Attack and decay follow hold-off counters. It sits between the FIR decimator output and the sample packer, and replaces the single global shift register.

Parameters:
NUM_CHANS, 13, channels; lanes = 2*NUM_CHANS; must be >= 2.
DATA_WIDTH, 41, signed FIR output width.
OUT_WIDTH, 16, signed output sample width.
MAX_SHIFT, 23, maximum shift (DATA_WIDTH-OUT_WIDTH-2).
INIT_SHIFT, 0, shift value after any reset.
ATTACK_HOLD, 4096, frames between successive shift increments.
DECAY_HOLD, 65536, consecutive quiet frames before a shift decrement.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
srst  in  1  synchronous soft clear, active-high (cfg reset bit)
s_tvalid  in  1  input sample valid; no backpressure
s_tdata  in  DATA_WIDTH  signed FIR sample
m_tvalid  out  1  output valid pulse
m_tdata  out  OUT_WIDTH  shifted, saturated sample
m_tlane  out  5  lane index of m_tdata (0..2*NUM_CHANS-1)
m_sat  out  1  m_tdata was saturated
cfg_manual  in  1  1 = manual shift mode
cfg_shift  in  5  manual shift value
shift_rd_chan  in  4  readback channel select
shift_rd_data  out  5  readback shift value, registered

Behaviour:
- aresetn low (async) and srst high (sync) have the same effect: lane counter=0, all shifts=INIT_SHIFT, all counters=0, pipeline valids=0. On aresetn low all outputs are also 0. srst is sampled every cycle, and an input in the same cycle is dropped.
- Lane counter advances on each s_tvalid and wraps from 2*NUM_CHANS-1 to 0. chan = lane>>1; lane bit0=1 is the imag lane.
- Pipeline:
  - S1 registers data, lane and shift[chan].
  - S2 computes data>>>shift (arithmetic) and saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - m_tvalid/m_tdata/m_tlane/m_sat are registered. Latency is 2 cycles from s_tvalid.
  - Outputs hold their values when m_tvalid=0.
- Per-sample flags, taken on the pre-saturation shifted value:
  - loud = value > 2^(OUT_WIDTH-2)-1 or < -2^(OUT_WIDTH-2).
  - quiet = -2^(OUT_WIDTH-3) < value < 2^(OUT_WIDTH-3)-1.
  - The real-lane flags are held until the imag lane of the same channel arrives.
- Per-channel update on the imag lane (S2). Define L = loudI|loudQ and Q = quietI&quietQ. Decisions use pre-update counter values:
  - if attack_cnt>0: attack_cnt--.
  - if L: quiet_cnt=0. If attack_cnt==0 and shift<MAX_SHIFT, then shift++ and attack_cnt=ATTACK_HOLD.
  - else if Q: if quiet_cnt==DECAY_HOLD-1, then quiet_cnt=0 and shift-- if shift>0; else quiet_cnt++.
  - else: quiet_cnt=0.
  - A new shift takes effect from the channel's next frame. The write is complete before the next read because NUM_CHANS >= 2.
- Shift saturates at 0 and MAX_SHIFT. It never wraps.
- Manual mode (cfg_manual=1):
  - On each imag lane, shift[chan] is written with min(cfg_shift, MAX_SHIFT) and both counters are cleared.
  - The value applies from the next frame.
  - When manual mode is released, automatic control resumes from that shift.
- Readback: shift_rd_data = shift[shift_rd_chan], registered with 1-cycle latency. Returns 0 if shift_rd_chan >= NUM_CHANS.
- Input gaps of any length are allowed. Counters advance per frame, not per clock.

Test Plan:
1. Reset: release aresetn, feed lane0 = 1000 → 2 cycles later m_tvalid=1, m_tdata=1000, m_tlane=0, m_sat=0; all shift readbacks = 0.
2. Attack (ATTACK_HOLD=4): ch3 I=40000, Q=0 every frame, other channels 0:
   - shift[3]=1 after frame 0; output 20000 from frame 1.
   - shift[3]=2 after frame 5; output 10000 from frame 6.
   - Other shifts stay 0.
3. Saturation at shift 0: lane0 = 100000 → 32767, m_sat=1; lane1 = -100000 → -32768, m_sat=1.
4. Decay (DECAY_HOLD=16):
   - ch0 at shift 2, I=Q=1000, outputs 250: shift becomes 1 after the 16th quiet frame, then outputs 500.
   - Repeat with one 20000<<2 sample injected at frame 8: the quiet count restarts and the decrement is delayed to 16 frames later.
5. Manual: cfg_manual=1, cfg_shift=30 → after one frame shift_rd_data=23 for every channel; input 2^30 → 128. Release manual with a loud input → shift stays 23 because it is at maximum.
6. srst mid-frame: pulse srst after lane 7 → next input reports m_tlane=0, all shifts = INIT_SHIFT, counters cleared, and the lane accepted in the srst cycle produces no output.

Source files
------------

// File: rtl/tdm_agc_ctrl_if.sv
// rtl/tdm_agc_ctrl_if.sv - sample stream bundle between FIR decimator, AGC and sample packer
interface tdm_agc_ctrl_if #(
    parameter int DATA_WIDTH = 41,
    parameter int OUT_WIDTH  = 16
);
    logic                         s_tvalid;
    logic signed [DATA_WIDTH-1:0] s_tdata;
    logic                         m_tvalid;
    logic signed [OUT_WIDTH-1:0]  m_tdata;
    logic [4:0]                   m_tlane;
    logic                         m_sat;

    modport slave (
        input  s_tvalid, s_tdata,
        output m_tvalid, m_tdata, m_tlane, m_sat
    );

    modport master (
        output s_tvalid, s_tdata,
        input  m_tvalid, m_tdata, m_tlane, m_sat
    );
endinterface

// File: rtl/tdm_agc_ctrl.sv
// rtl/tdm_agc_ctrl.sv - per-channel automatic gain (shift) control for the TDM FIR output stream
// Two-stage pipeline: S1 captures sample/lane/shift, S2 shifts, saturates and updates the channel AGC.
module tdm_agc_ctrl #(
    parameter int NUM_CHANS   = 13,
    parameter int DATA_WIDTH  = 41,
    parameter int OUT_WIDTH   = 16,
    parameter int MAX_SHIFT   = 23,
    parameter int INIT_SHIFT  = 0,
    parameter int ATTACK_HOLD = 4096,
    parameter int DECAY_HOLD  = 65536
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          srst,
    tdm_agc_ctrl_if.slave s,
    input  logic          cfg_manual,
    input  logic [4:0]    cfg_shift,
    input  logic [3:0]    shift_rd_chan,
    output logic [4:0]    shift_rd_data
);
    localparam int AW = $clog2(ATTACK_HOLD + 1);
    localparam int QW = $clog2(DECAY_HOLD + 1);
    localparam logic [4:0]    LAST_LANE  = 5'(2 * NUM_CHANS - 1);
    localparam logic [4:0]    NCH        = 5'(NUM_CHANS);
    localparam logic [4:0]    SH_MAX     = 5'(MAX_SHIFT);
    localparam logic [4:0]    SH_INIT    = 5'(INIT_SHIFT);
    localparam logic [AW-1:0] ATT_RELOAD = AW'(ATTACK_HOLD);
    localparam logic [QW-1:0] QUIET_LAST = QW'(DECAY_HOLD - 1);
    localparam logic signed [DATA_WIDTH-1:0] SAT_HI   = DATA_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [DATA_WIDTH-1:0] SAT_LO   = ~SAT_HI;
    localparam logic signed [DATA_WIDTH-1:0] LOUD_HI  = DATA_WIDTH'((1 << (OUT_WIDTH - 2)) - 1);
    localparam logic signed [DATA_WIDTH-1:0] LOUD_LO  = ~LOUD_HI;
    localparam logic signed [DATA_WIDTH-1:0] QUIET_HI = DATA_WIDTH'((1 << (OUT_WIDTH - 3)) - 1);
    localparam logic signed [DATA_WIDTH-1:0] QUIET_LO = ~QUIET_HI;

    logic [4:0]                   lane_q, lane_d;
    logic [4:0]                   shift_q [NUM_CHANS];
    logic [4:0]                   shift_d [NUM_CHANS];
    logic [AW-1:0]                attack_q [NUM_CHANS];
    logic [AW-1:0]                attack_d [NUM_CHANS];
    logic [QW-1:0]                quiet_q [NUM_CHANS];
    logic [QW-1:0]                quiet_d [NUM_CHANS];
    logic                         s1_valid_q, s1_valid_d;
    logic signed [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [4:0]                   s1_lane_q, s1_lane_d;
    logic [4:0]                   s1_shift_q, s1_shift_d;
    logic                         real_loud_q, real_loud_d;
    logic                         real_quiet_q, real_quiet_d;
    logic                         m_tvalid_q, m_tvalid_d;
    logic [OUT_WIDTH-1:0]         m_tdata_q, m_tdata_d;
    logic [4:0]                   m_tlane_q, m_tlane_d;
    logic                         m_sat_q, m_sat_d;
    logic [4:0]                   shift_rd_q, shift_rd_d;

    logic [3:0]                   in_chan, s2_chan;
    logic signed [DATA_WIDTH-1:0] shifted;
    logic                         loud, quiet, grp_loud, grp_quiet;

    always_comb begin
        lane_d       = lane_q;
        shift_d      = shift_q;
        attack_d     = attack_q;
        quiet_d      = quiet_q;
        s1_valid_d   = s.s_tvalid;
        s1_data_d    = s1_data_q;
        s1_lane_d    = s1_lane_q;
        s1_shift_d   = s1_shift_q;
        real_loud_d  = real_loud_q;
        real_quiet_d = real_quiet_q;
        m_tvalid_d   = s1_valid_q;
        m_tdata_d    = m_tdata_q;
        m_tlane_d    = m_tlane_q;
        m_sat_d      = m_sat_q;
        in_chan      = lane_q[4:1];
        s2_chan      = s1_lane_q[4:1];

        if (s.s_tvalid) begin
            lane_d     = (lane_q == LAST_LANE) ? 5'd0 : lane_q + 5'd1;
            s1_data_d  = s.s_tdata;
            s1_lane_d  = lane_q;
            s1_shift_d = shift_q[in_chan];
        end

        // Flags are judged on the shifted value before it is clipped to OUT_WIDTH.
        shifted   = s1_data_q >>> s1_shift_q;
        loud      = (shifted > LOUD_HI) || (shifted < LOUD_LO);
        quiet     = (shifted > QUIET_LO) && (shifted < QUIET_HI);
        grp_loud  = real_loud_q | loud;
        grp_quiet = real_quiet_q & quiet;

        if (s1_valid_q) begin
            m_tlane_d = s1_lane_q;
            m_sat_d   = 1'b1;
            if (shifted > SAT_HI) begin
                m_tdata_d = SAT_HI[OUT_WIDTH-1:0];
            end else if (shifted < SAT_LO) begin
                m_tdata_d = SAT_LO[OUT_WIDTH-1:0];
            end else begin
                m_tdata_d = shifted[OUT_WIDTH-1:0];
                m_sat_d   = 1'b0;
            end

            if (!s1_lane_q[0]) begin
                real_loud_d  = loud;
                real_quiet_d = quiet;
            end else if (cfg_manual) begin
                shift_d[s2_chan]  = (cfg_shift > SH_MAX) ? SH_MAX : cfg_shift;
                attack_d[s2_chan] = '0;
                quiet_d[s2_chan]  = '0;
            end else begin
                if (attack_q[s2_chan] != '0) begin
                    attack_d[s2_chan] = attack_q[s2_chan] - 1'b1;
                end
                if (grp_loud) begin
                    quiet_d[s2_chan] = '0;
                    if (attack_q[s2_chan] == '0 && shift_q[s2_chan] < SH_MAX) begin
                        shift_d[s2_chan]  = shift_q[s2_chan] + 5'd1;
                        attack_d[s2_chan] = ATT_RELOAD;
                    end
                end else if (grp_quiet) begin
                    if (quiet_q[s2_chan] == QUIET_LAST) begin
                        quiet_d[s2_chan] = '0;
                        if (shift_q[s2_chan] != 5'd0) begin
                            shift_d[s2_chan] = shift_q[s2_chan] - 5'd1;
                        end
                    end else begin
                        quiet_d[s2_chan] = quiet_q[s2_chan] + 1'b1;
                    end
                end else begin
                    quiet_d[s2_chan] = '0;
                end
            end
        end

        shift_rd_d = ({1'b0, shift_rd_chan} < NCH) ? shift_q[shift_rd_chan] : 5'd0;

        // Soft clear wins over everything, including a sample arriving this cycle.
        if (srst) begin
            lane_d       = 5'd0;
            s1_valid_d   = 1'b0;
            m_tvalid_d   = 1'b0;
            real_loud_d  = 1'b0;
            real_quiet_d = 1'b0;
            for (int i = 0; i < NUM_CHANS; i++) begin
                shift_d[i]  = SH_INIT;
                attack_d[i] = '0;
                quiet_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lane_q       <= 5'd0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_lane_q    <= 5'd0;
            s1_shift_q   <= 5'd0;
            real_loud_q  <= 1'b0;
            real_quiet_q <= 1'b0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tlane_q    <= 5'd0;
            m_sat_q      <= 1'b0;
            shift_rd_q   <= 5'd0;
            for (int i = 0; i < NUM_CHANS; i++) begin
                shift_q[i]  <= SH_INIT;
                attack_q[i] <= '0;
                quiet_q[i]  <= '0;
            end
        end else begin
            lane_q       <= lane_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_lane_q    <= s1_lane_d;
            s1_shift_q   <= s1_shift_d;
            real_loud_q  <= real_loud_d;
            real_quiet_q <= real_quiet_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tlane_q    <= m_tlane_d;
            m_sat_q      <= m_sat_d;
            shift_rd_q   <= shift_rd_d;
            shift_q      <= shift_d;
            attack_q     <= attack_d;
            quiet_q      <= quiet_d;
        end
    end

    assign s.m_tvalid    = m_tvalid_q;
    assign s.m_tdata     = m_tdata_q;
    assign s.m_tlane     = m_tlane_q;
    assign s.m_sat       = m_sat_q;
    assign shift_rd_data = shift_rd_q;
endmodule

// File: tb/tb_tdm_agc_ctrl.sv
// tb/tb_tdm_agc_ctrl.sv - self-checking bench for tdm_agc_ctrl against a frame-level gain model
module tb_tdm_agc_ctrl;
    localparam int NCH  = 13;
    localparam int DW   = 41;
    localparam int OW   = 16;
    localparam int MAXS = 23;
    localparam int AH   = 4;
    localparam int DH   = 16;

    logic       aclk;
    logic       aresetn;
    logic       srst;
    logic       cfg_manual;
    logic [4:0] cfg_shift;
    logic [3:0] shift_rd_chan;
    logic [4:0] shift_rd_data;

    tdm_agc_ctrl_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

    tdm_agc_ctrl #(
        .NUM_CHANS(NCH), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .MAX_SHIFT(MAXS),
        .INIT_SHIFT(0), .ATTACK_HOLD(AH), .DECAY_HOLD(DH)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .s(bus.slave),
        .cfg_manual(cfg_manual), .cfg_shift(cfg_shift),
        .shift_rd_chan(shift_rd_chan), .shift_rd_data(shift_rd_data)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        longint data;
        int     lane;
        bit     sat;
    } exp_t;

    exp_t   expq[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    int     m_sh[NCH];
    int     m_att[NCH];
    int     m_qc[NCH];
    int     m_lane;
    bit     m_rl, m_rq;
    longint pat_i[NCH];
    longint pat_q[NCH];

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_sh[i] = 0; m_att[i] = 0; m_qc[i] = 0;
        end
        m_lane = 0; m_rl = 0; m_rq = 0;
    endtask

    // Gain rules applied at frame level: one decision per channel per I/Q pair.
    task automatic model_push(input longint d);
        int     ch, att0;
        longint v;
        exp_t   e;
        bit     loud, quiet, grp_l, grp_q;
        ch = m_lane / 2;
        v  = d >>> m_sh[ch];
        e.lane = m_lane;
        e.sat  = 1'b1;
        if (v > 32767) e.data = 32767;
        else if (v < -32768) e.data = -32768;
        else begin e.data = v; e.sat = 1'b0; end
        expq.push_back(e);
        loud  = (v > 16383) || (v < -16384);
        quiet = (v > -4096) && (v < 4095);
        if (m_lane % 2 == 0) begin
            m_rl = loud; m_rq = quiet;
        end else if (cfg_manual) begin
            m_sh[ch]  = (int'(cfg_shift) > MAXS) ? MAXS : int'(cfg_shift);
            m_att[ch] = 0; m_qc[ch] = 0;
        end else begin
            grp_l = m_rl | loud;
            grp_q = m_rq & quiet;
            att0  = m_att[ch];
            if (att0 > 0) m_att[ch] = att0 - 1;
            if (grp_l) begin
                m_qc[ch] = 0;
                if (att0 == 0 && m_sh[ch] < MAXS) begin
                    m_sh[ch]++; m_att[ch] = AH;
                end
            end else if (grp_q) begin
                if (m_qc[ch] == DH - 1) begin
                    m_qc[ch] = 0;
                    if (m_sh[ch] > 0) m_sh[ch]--;
                end else m_qc[ch]++;
            end else m_qc[ch] = 0;
        end
        m_lane = (m_lane + 1) % (2 * NCH);
    endtask

    task automatic send(input longint d);
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = DW'(d);
        model_push(d);
        @(posedge aclk); #1;
        bus.s_tvalid = 1'b0;
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int c = 0; c < NCH; c++) begin
                send(pat_i[c]); gap();
                send(pat_q[c]); gap();
            end
    endtask

    task automatic set_pat(input longint vi, input longint vq);
        for (int c = 0; c < NCH; c++) begin pat_i[c] = vi; pat_q[c] = vq; end
    endtask

    task automatic drain();
        repeat (3) begin @(posedge aclk); #1; end
        chk("drain_pending", expq.size(), 0);
    endtask

    task automatic rd_chk(input int ch, input int exp, input string tag);
        shift_rd_chan = 4'(ch);
        @(posedge aclk); #1;
        chk(tag, shift_rd_data, exp);
    endtask

    task automatic check_all_shifts(input string tag);
        for (int ch = 0; ch < 16; ch++)
            rd_chk(ch, (ch < NCH) ? m_sh[ch] : 0, $sformatf("%s_rd%0d", tag, ch));
    endtask

    function automatic longint rnd_sample();
        longint mag;
        mag = (64'sd1 <<< $urandom_range(4, 38)) + longint'($urandom_range(0, 255));
        return ($urandom_range(0, 1) == 1) ? -mag : mag;
    endfunction

    always @(negedge aclk) begin
        exp_t e;
        if (aresetn && bus.m_tvalid) begin
            n_assert++;
            assert (expq.size() > 0) else begin
                n_fail++;
                $error("FAIL out_unexpected: observed lane %0d with no pending sample, expected none", bus.m_tlane);
            end
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("out_data", $signed(bus.m_tdata), e.data);
                chk("out_lane", bus.m_tlane, e.lane);
                chk("out_sat", bus.m_sat, e.sat);
            end
        end
    end

    initial begin
        aresetn = 1'b0; srst = 1'b0; cfg_manual = 1'b0; cfg_shift = 5'd0;
        shift_rd_chan = 4'd0; bus.s_tvalid = 1'b0; bus.s_tdata = '0;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", bus.m_tvalid, 0);
        chk("rst_tdata", bus.m_tdata, 0);
        chk("rst_tlane", bus.m_tlane, 0);
        chk("rst_sat", bus.m_sat, 0);
        chk("rst_rd", shift_rd_data, 0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        send(1000);
        chk("lat_early_valid", bus.m_tvalid, 0);
        @(posedge aclk); #1;
        chk("lat_valid", bus.m_tvalid, 1);
        chk("lat_data", $signed(bus.m_tdata), 1000);
        chk("lat_lane", bus.m_tlane, 0);
        chk("lat_sat", bus.m_sat, 0);
        while (m_lane != 0) begin send(0); gap(); end
        drain();
        check_all_shifts("init");

        set_pat(0, 0);
        pat_i[3] = 40000;
        run_frames(1);
        drain();
        rd_chk(3, 1, "attack_f0");
        run_frames(5);
        drain();
        rd_chk(3, 2, "attack_f5");
        rd_chk(2, 0, "attack_other");
        check_all_shifts("attack");

        set_pat(0, 0);
        pat_i[0] = 100000;
        pat_q[0] = -100000;
        run_frames(1);
        drain();

        set_pat(0, 0);
        cfg_manual = 1'b1; cfg_shift = 5'd2;
        run_frames(1);
        drain();
        cfg_manual = 1'b0;
        set_pat(1000, 1000);
        run_frames(15);
        drain();
        rd_chk(0, 2, "decay_before");
        run_frames(1);
        drain();
        rd_chk(0, 1, "decay_after");
        run_frames(1);
        drain();

        set_pat(0, 0);
        cfg_manual = 1'b1; cfg_shift = 5'd2;
        run_frames(1);
        drain();
        cfg_manual = 1'b0;
        set_pat(1000, 1000);
        run_frames(8);
        pat_i[0] = 64'sd20000 <<< 2;
        run_frames(1);
        pat_i[0] = 1000;
        run_frames(15);
        drain();
        rd_chk(0, 3, "restart_hold");
        run_frames(1);
        drain();
        rd_chk(0, 2, "restart_decay");

        set_pat(0, 0);
        cfg_manual = 1'b1; cfg_shift = 5'd30;
        run_frames(1);
        drain();
        check_all_shifts("manual");
        rd_chk(5, 23, "manual_clamp");
        pat_i[0] = 64'sd1 <<< 30;
        run_frames(1);
        drain();
        cfg_manual = 1'b0;
        pat_i[0] = 64'sd1 <<< 39;
        run_frames(1);
        drain();
        rd_chk(0, 23, "manual_release_max");

        for (int blk = 0; blk < 3; blk++) begin
            for (int f = 0; f < 10; f++) begin
                for (int c = 0; c < NCH; c++) begin
                    pat_i[c] = rnd_sample(); pat_q[c] = rnd_sample();
                end
                run_frames(1);
            end
            drain();
            check_all_shifts($sformatf("rand%0d", blk));
            cfg_manual = 1'b1; cfg_shift = 5'($urandom_range(0, 31));
            run_frames(1);
            drain();
            cfg_manual = 1'b0;
        end

        for (int i = 0; i < 8; i++) send(64'sd1 <<< 38);
        drain();
        srst = 1'b1;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = DW'(64'sd12345);
        @(posedge aclk); #1;
        srst = 1'b0;
        bus.s_tvalid = 1'b0;
        model_reset();
        drain();
        check_all_shifts("srst");
        send(777);
        @(posedge aclk); #1;
        chk("srst_valid", bus.m_tvalid, 1);
        chk("srst_lane", bus.m_tlane, 0);
        send(100000);
        while (m_lane != 0) send(0);
        drain();
        rd_chk(0, 1, "srst_attack_clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
